// File: rtl/life_mode_sequencer.sv
// Mode sequencer for the Game-of-Life system memory: runs one LOAD, RUN or DUMP
// host command at a time and drives the mutually exclusive memory mode strobes.
module life_mode_sequencer #(
  parameter int DATA_SIZE = 64,
  parameter int GEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [GEN_WIDTH-1:0] cmd_gens,
  input  logic                 serial_valid,
  input  logic                 run_tick,
  input  logic                 abort,
  output logic                 load_mode,
  output logic                 run_mode,
  output logic                 output_mode,
  output logic                 serial_out_valid,
  output logic                 busy,
  output logic                 done,
  output logic [GEN_WIDTH-1:0] gen_count
);

  localparam int BIT_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_SIZE - 1);

  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_DUMP = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DUMP} state_t;

  state_t               state_q, state_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GEN_WIDTH-1:0] gen_count_q, gen_count_d;
  logic [GEN_WIDTH-1:0] gens_q, gens_d;
  logic                 done_q, done_d;
  logic                 sov_q;
  logic [GEN_WIDTH-1:0] gen_next;

  assign gen_next = gen_count_q + GEN_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    gen_count_d = gen_count_q;
    gens_d      = gens_q;
    done_d      = 1'b0;
    load_mode   = (state_q == S_LOAD) && serial_valid && !abort;
    run_mode    = (state_q == S_RUN) && run_tick && !abort;
    output_mode = (state_q == S_DUMP) && !abort;

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (cmd_valid) begin
          case (cmd_op)
            OP_LOAD: state_d = S_LOAD;
            OP_RUN: begin
              state_d     = S_RUN;
              gen_count_d = '0;
              gens_d      = cmd_gens;
            end
            OP_DUMP: state_d = S_DUMP;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d   = S_IDLE;
          bit_cnt_d = '0;
        end else if (load_mode) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      S_RUN: begin
        // gens_q == 0 is free-run: only abort leaves, and gen_count wraps.
        if (abort) begin
          state_d = S_IDLE;
        end else if (run_mode) begin
          gen_count_d = gen_next;
          if ((gens_q != '0) && (gen_next == gens_q)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_DUMP: begin
        if (abort) begin
          state_d   = S_IDLE;
          bit_cnt_d = '0;
        end else if (bit_cnt_q == LAST_BIT) begin
          state_d   = S_IDLE;
          bit_cnt_d = '0;
          done_d    = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      gen_count_q <= '0;
      gens_q      <= '0;
      done_q      <= 1'b0;
      sov_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      gen_count_q <= gen_count_d;
      gens_q      <= gens_d;
      done_q      <= done_d;
      // Memory serial_out is registered, so its valid flag lags output_mode by one cycle.
      sov_q       <= output_mode;
    end
  end

  assign cmd_ready        = (state_q == S_IDLE);
  assign busy             = (state_q != S_IDLE);
  assign done             = done_q;
  assign serial_out_valid = sov_q;
  assign gen_count        = gen_count_q;

endmodule

// File: tb/tb_life_mode_sequencer.sv
// Bench for life_mode_sequencer: table vectors, directed multi-cycle sequences and
// random stimulus, all checked against a command-level reference model.
module tb_life_mode_sequencer;

  localparam int DS = 64;
  localparam int GW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [GW-1:0] cmd_gens;
  logic          serial_valid, run_tick, abort;
  logic          load_mode, run_mode, output_mode, serial_out_valid, busy, done;
  logic [GW-1:0] gen_count;

  always #5 clk = ~clk;

  life_mode_sequencer #(.DATA_SIZE(DS), .GEN_WIDTH(GW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_gens(cmd_gens), .serial_valid(serial_valid),
    .run_tick(run_tick), .abort(abort), .load_mode(load_mode), .run_mode(run_mode),
    .output_mode(output_mode), .serial_out_valid(serial_out_valid), .busy(busy),
    .done(done), .gen_count(gen_count)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: which command is active and how much of it remains.
  typedef enum {M_IDLE, M_LOAD, M_RUN, M_DUMP} mcmd_t;
  mcmd_t       m_cmd;
  int          m_left;
  int unsigned m_target;
  int unsigned m_gc;
  bit          m_done, m_sov, e_om_saved;

  // External memory model plus activity counters taken from the DUT strobes.
  logic [DS-1:0] mem, dumped;
  logic          sin, sout;
  int            n_lm, n_rm, n_om, n_done, n_dumped;

  localparam logic [DS-1:0] PATTERN = 64'hF0F0_0000_0000_00A5;

  typedef struct {
    logic cv; logic [1:0] op; logic [GW-1:0] gens; logic sv, tk, ab;
    logic e_ready, e_busy, e_lm, e_rm, e_om, e_done; logic [GW-1:0] e_gc;
  } vec_t;
  vec_t vt[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cmd = M_IDLE; m_left = 0; m_target = 0; m_gc = 0; m_done = 0; m_sov = 0;
  endtask

  task automatic clear_counts();
    n_lm = 0; n_rm = 0; n_om = 0; n_done = 0; n_dumped = 0;
  endtask

  // Settle, compare every output with the model, and record DUT activity.
  task automatic settle_check();
    bit e_lm, e_rm, e_om;
    #1;
    e_lm = (m_cmd == M_LOAD) && serial_valid && !abort;
    e_rm = (m_cmd == M_RUN) && run_tick && !abort;
    e_om = (m_cmd == M_DUMP) && !abort;
    chk("cmd_ready", 64'(cmd_ready), 64'(m_cmd == M_IDLE));
    chk("busy", 64'(busy), 64'(m_cmd != M_IDLE));
    chk("load_mode", 64'(load_mode), 64'(e_lm));
    chk("run_mode", 64'(run_mode), 64'(e_rm));
    chk("output_mode", 64'(output_mode), 64'(e_om));
    chk("serial_out_valid", 64'(serial_out_valid), 64'(m_sov));
    chk("done", 64'(done), 64'(m_done));
    chk("gen_count", 64'(gen_count), 64'(m_gc));
    e_om_saved = e_om;
    n_lm += int'(load_mode); n_rm += int'(run_mode); n_om += int'(output_mode);
    n_done += int'(done);
    if (serial_out_valid) begin dumped = {dumped[DS-2:0], sout}; n_dumped++; end
    if (load_mode) mem = {mem[DS-2:0], sin};
    else if (output_mode) begin sout = mem[DS-1]; mem = {mem[DS-2:0], 1'b0}; end
  endtask

  // Clock edge, then advance the command-level model from the held inputs.
  task automatic advance();
    bit nd;
    @(posedge clk);
    nd = 0;
    m_sov = e_om_saved;
    if (m_cmd == M_IDLE) begin
      if (cmd_valid) begin
        case (cmd_op)
          2'd1: begin m_cmd = M_LOAD; m_left = DS; end
          2'd2: begin m_cmd = M_RUN; m_gc = 0; m_target = cmd_gens; end
          2'd3: begin m_cmd = M_DUMP; m_left = DS; end
          default: ;
        endcase
      end
    end else if (abort) begin
      m_cmd = M_IDLE;
    end else if (m_cmd == M_LOAD) begin
      if (serial_valid) begin
        m_left--;
        if (m_left == 0) begin m_cmd = M_IDLE; nd = 1; end
      end
    end else if (m_cmd == M_RUN) begin
      if (run_tick) begin
        m_gc = (m_gc + 1) % (1 << GW);
        if (m_target != 0 && m_gc == m_target) begin m_cmd = M_IDLE; nd = 1; end
      end
    end else begin
      m_left--;
      if (m_left == 0) begin m_cmd = M_IDLE; nd = 1; end
    end
    m_done = nd;
    #1;
  endtask

  task automatic step();
    settle_check();
    advance();
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_op = 2'd0; cmd_gens = '0; serial_valid = 0; run_tick = 0; abort = 0; sin = 0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [GW-1:0] gens);
    cmd_valid = 1; cmd_op = op; cmd_gens = gens;
    step();
    cmd_valid = 0; cmd_op = 2'd0;
  endtask

  initial begin
    vt[0] = '{1'b1, 2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vt[1] = '{1'b1, 2'd2, 16'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vt[2] = '{1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vt[3] = '{1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    vt[4] = '{1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1};
    vt[5] = '{1'b1, 2'd2, 16'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2};
    vt[6] = '{1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    vt[7] = '{1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    vt[8] = '{1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};

    idle_inputs();
    mem = '0; dumped = '0; sout = 0;
    clear_counts();
    model_reset();
    reset = 1;
    #1;
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_modes", 64'({load_mode, run_mode, output_mode}), 64'd0);
    chk("rst_done_sov", 64'({done, serial_out_valid}), 64'd0);
    chk("rst_gen_count", 64'(gen_count), 64'd0);
    @(posedge clk); #1;
    reset = 0;

    // Table vectors: NOP, abort ignored in IDLE, short RUN, accept in done cycle, abort in RUN.
    for (int i = 0; i < 9; i++) begin
      cmd_valid = vt[i].cv; cmd_op = vt[i].op; cmd_gens = vt[i].gens;
      serial_valid = vt[i].sv; run_tick = vt[i].tk; abort = vt[i].ab;
      settle_check();
      chk($sformatf("vec%0d_ready", i), 64'(cmd_ready), 64'(vt[i].e_ready));
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vt[i].e_busy));
      chk($sformatf("vec%0d_modes", i), 64'({load_mode, run_mode, output_mode}),
          64'({vt[i].e_lm, vt[i].e_rm, vt[i].e_om}));
      chk($sformatf("vec%0d_done", i), 64'(done), 64'(vt[i].e_done));
      chk($sformatf("vec%0d_gc", i), 64'(gen_count), 64'(vt[i].e_gc));
      advance();
    end
    idle_inputs();

    // LOAD with serial_valid every other cycle.
    clear_counts();
    issue(2'd1, '0);
    for (int c = 0; c < 300 && n_done == 0; c++) begin
      serial_valid = c[0];
      sin = (n_lm < DS) ? PATTERN[DS-1-n_lm] : 1'b0;
      step();
    end
    idle_inputs();
    chk("load_pulses", 64'(n_lm), 64'(DS));
    chk("load_done", 64'(n_done), 64'd1);
    chk("load_mem", mem, PATTERN);

    // DUMP with a RUN command held pending until the done cycle.
    clear_counts();
    issue(2'd3, '0);
    cmd_valid = 1; cmd_op = 2'd2; cmd_gens = 16'd1;
    for (int c = 0; c < 200 && n_done == 0; c++) step();
    cmd_valid = 0; cmd_op = 2'd0;
    chk("dump_om_count", 64'(n_om), 64'(DS));
    chk("dump_valid_count", 64'(n_dumped), 64'(DS));
    chk("dump_bits", dumped, PATTERN);
    chk("accept_in_done", 64'(busy), 64'd1);
    run_tick = 1;
    clear_counts();
    for (int c = 0; c < 20 && n_done == 0; c++) step();
    chk("held_run_gens", 64'(n_rm), 64'd1);
    idle_inputs();
    step();

    // RUN 5 with continuous tick, then with toggling tick.
    clear_counts();
    issue(2'd2, 16'd5);
    run_tick = 1;
    for (int c = 0; c < 20 && n_done == 0; c++) step();
    chk("run5_pulses", 64'(n_rm), 64'd5);
    chk("run5_gc", 64'(gen_count), 64'd5);
    clear_counts();
    issue(2'd2, 16'd5);
    for (int c = 0; c < 40 && n_done == 0; c++) begin run_tick = c[0]; step(); end
    chk("run5_toggle_pulses", 64'(n_rm), 64'd5);
    idle_inputs();

    // Free-run, then abort after 300 generations.
    clear_counts();
    issue(2'd2, 16'd0);
    run_tick = 1;
    for (int c = 0; c < 300; c++) step();
    abort = 1;
    settle_check();
    chk("freerun_gc", 64'(gen_count), 64'd300);
    chk("abort_modes", 64'({load_mode, run_mode, output_mode}), 64'd0);
    advance();
    idle_inputs();
    settle_check();
    chk("abort_idle", 64'({cmd_ready, busy, done}), 64'b100);
    chk("freerun_no_done", 64'(n_done), 64'd0);
    advance();

    // Asynchronous reset in the middle of a LOAD.
    clear_counts();
    issue(2'd1, '0);
    serial_valid = 1;
    for (int c = 0; c < 10; c++) step();
    reset = 1;
    #1;
    chk("midrst_modes", 64'({load_mode, run_mode, output_mode, serial_out_valid, done}), 64'd0);
    chk("midrst_ready_busy", 64'({cmd_ready, busy}), 64'b10);
    model_reset();
    @(posedge clk); #1;
    reset = 0;
    idle_inputs();
    clear_counts();
    issue(2'd1, '0);
    serial_valid = 1;
    for (int c = 0; c < 100 && n_done == 0; c++) step();
    chk("reload_pulses", 64'(n_lm), 64'(DS));
    idle_inputs();

    // Random commands and inputs against the model.
    for (int c = 0; c < 3000; c++) begin
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_op = 2'($urandom_range(0, 3));
      cmd_gens = GW'($urandom_range(0, 6));
      serial_valid = 1'($urandom_range(0, 1));
      run_tick = 1'($urandom_range(0, 1));
      abort = ($urandom_range(0, 40) == 0);
      sin = 1'($urandom_range(0, 1));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/life_mode_sequencer.md
Name: life_mode_sequencer

Overview:
- FSM that sequences the Game-of-Life system memory (input/output shift-register pair) by driving its mutually exclusive load_mode, run_mode and output_mode controls.
- Accepts one command at a time from the host interface: LOAD, RUN and DUMP.
- Counts serial bits and generations, and flags valid serial output bits.
- Sits between the external serial/host interface and the system memory.

Parameters:
- DATA_SIZE, 64, grid bits held in system memory (bits per LOAD/DUMP).
- GEN_WIDTH, 16, width of generation count fields.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; returns block to IDLE.
- cmd_valid  input  1  host command strobe.
- cmd_ready  output  1  high when a command can be accepted (state IDLE).
- cmd_op  input  2  00 NOP, 01 LOAD, 10 RUN, 11 DUMP.
- cmd_gens  input  GEN_WIDTH  generations for RUN; 0 = free-run until abort.
- serial_valid  input  1  external serial_in bit present this cycle (LOAD only).
- run_tick  input  1  generation enable; RUN advances one generation per cycle with run_tick high.
- abort  input  1  synchronous cancel of any active command.
- load_mode  output  1  to memory: shift serial_in in.
- run_mode  output  1  to memory: capture grid_in.
- output_mode  output  1  to memory: shift one bit to serial_out.
- serial_out_valid  output  1  memory serial_out holds a valid grid bit this cycle.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle completion pulse.
- gen_count  output  GEN_WIDTH  generations completed in the current/last RUN.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high. In reset:
  - state = IDLE.
  - Bit counter, gen counter and gen_count = 0.
  - All mode outputs, serial_out_valid and done = 0.
  - busy = 0, cmd_ready = 1.
- States are IDLE, LOAD, RUN and DUMP. Transitions are registered; outputs are decoded as below.
- Command accept: a command is accepted when cmd_valid & cmd_ready. cmd_op and cmd_gens are sampled on that edge.
  - NOP: stays IDLE, no done.
  - LOAD, RUN, DUMP: enter the corresponding state next cycle.
  - There is no mode activity in the accept cycle itself.
- LOAD:
  - load_mode = serial_valid & ~abort (combinational). Cycles without serial_valid stall without shifting.
  - Bit counter increments on each load_mode cycle.
  - On the DATA_SIZE-th load_mode cycle, next state is IDLE.
- RUN:
  - run_mode = run_tick & ~abort (combinational).
  - gen_count is cleared on RUN accept and increments on each run_mode cycle; it wraps modulo 2^GEN_WIDTH in free-run.
  - If cmd_gens != 0, the RUN ends after the run_mode cycle that makes gen_count == cmd_gens.
  - If cmd_gens == 0, the block runs until abort.
  - gen_count holds its value in IDLE until the next RUN accept.
- DUMP:
  - output_mode = ~abort for exactly DATA_SIZE consecutive cycles; counted by the bit counter, no stalls.
  - Then next state is IDLE.
- serial_out_valid: register of output_mode, i.e. high the cycle after each output_mode cycle. This matches the memory's registered serial_out; MSB first.
- done:
  - Registered; pulses high the cycle after the final mode cycle of a LOAD, a RUN with nonzero cmd_gens, or a DUMP. The block is already in IDLE in that cycle.
  - For DUMP, done coincides with the last serial_out_valid.
  - A new command may be accepted in the done cycle.
- RUN with cmd_gens == 0 never pulses done.
- Mutual exclusion: at most one of load_mode, run_mode and output_mode is ever high.
- abort:
  - In any non-IDLE state: forces all mode outputs low that cycle, next state IDLE, counters cleared except gen_count, no done.
  - A serial_out_valid from the previous cycle's output_mode still appears in the abort cycle.
  - abort in IDLE is ignored; a command is still accepted if cmd_valid is high.
- Reset mid-command: immediate return to reset values, no done; the memory's own reset clears its contents.
- Commands presented while busy are not accepted (cmd_ready = 0); the host holds cmd_valid.

Test Plan:
- LOAD, DATA_SIZE=64, serial_valid high every other cycle: exactly 64 load_mode pulses, each coincident with serial_valid; done 1 cycle after the 64th; busy low with done.
- RUN cmd_gens=5, run_tick continuously high: run_mode high 5 consecutive cycles, gen_count 0→5, done next cycle; then with run_tick toggling, 5 run_mode pulses only on tick cycles.
- DUMP after loading pattern 0xF0F0_0000_0000_00A5: output_mode high 64 cycles; serial_out_valid high 64 cycles delayed by 1; sampled bits = pattern MSB first; done with last valid.
- RUN cmd_gens=0, tick every cycle, abort after 300 cycles: gen_count = 300; modes low in the abort cycle; IDLE next cycle; no done; cmd_ready=1.
- Command while busy, plus NOP: cmd_valid held during a DUMP is accepted only in the done cycle; NOP gives no state change and no done.
- Async reset asserted mid-LOAD (after 10 bits): all outputs immediately 0, cmd_ready=1; a subsequent LOAD requires a full 64 bits.
